// File: rtl/wfg_stim_sine_top.sv
// Sine stimulus: phase accumulator -> 16-step CORDIC -> gain/offset/saturate -> AXI-S.
// Latency: first sample 18 cycles after the sequencer leaves IDLE, then one per handshake + 18.
// Backpressure: tdata is held while tready is low; the phase only advances on accept.
module wfg_stim_sine_top #(
   parameter int BUSW = 32
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                wbs_stb_i,
   input  logic                wbs_cyc_i,
   input  logic                wbs_we_i,
   input  logic [3:0]          wbs_sel_i,
   input  logic [BUSW-1:0]     wbs_dat_i,
   input  logic [BUSW-1:0]     wbs_adr_i,
   output logic                wbs_ack_o,
   output logic [BUSW-1:0]     wbs_dat_o,
   input  logic                wfg_stim_spi_tready_o,
   output logic                wfg_stim_spi_tvalid_i,
   output logic signed [17:0]  wfg_stim_spi_tdata_i
);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, VALID = 2'd2} state_t;

   // 1/K for 16 iterations, with 1.0 = 2^20 inside the CORDIC
   localparam logic signed [23:0] X_INIT = 24'sd636749;

   logic               ctrl_en;
   logic [15:0]        inc_r;
   logic [15:0]        gain_r;
   logic signed [17:0] offset_r;
   logic               req;
   logic [BUSW-1:0]    rd_mux;

   state_t             state;
   logic [4:0]         cnt;
   logic [15:0]        phase;
   logic [15:0]        phase_nxt;
   logic [1:0]         quad;
   logic signed [23:0] cx, cy;
   logic signed [18:0] cz;
   logic signed [34:0] prod;

   logic [3:0]         shift;
   logic signed [23:0] x_sh, y_sh, x_nxt, y_nxt;
   logic signed [18:0] step, z_nxt;
   logic signed [23:0] unf, rnd;
   logic signed [17:0] sin_s;
   logic signed [34:0] sin_ext, gain_ext, scaled, sum;
   logic signed [17:0] sat;
   logic               unused_bits;

   assign req       = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
   assign phase_nxt = phase + inc_r;
   assign unused_bits = ^{wbs_adr_i[BUSW-1:8], wbs_dat_i[BUSW-1:18], wbs_sel_i[3], rnd[23:18]};

   // arctan(2^-i) in units where a full turn is 2^18
   function automatic logic [15:0] atan_lut(input logic [3:0] i);
      case (i)
         4'd0:    atan_lut = 16'd32768;
         4'd1:    atan_lut = 16'd19344;
         4'd2:    atan_lut = 16'd10221;
         4'd3:    atan_lut = 16'd5188;
         4'd4:    atan_lut = 16'd2604;
         4'd5:    atan_lut = 16'd1303;
         4'd6:    atan_lut = 16'd652;
         4'd7:    atan_lut = 16'd326;
         4'd8:    atan_lut = 16'd163;
         4'd9:    atan_lut = 16'd81;
         4'd10:   atan_lut = 16'd41;
         4'd11:   atan_lut = 16'd20;
         4'd12:   atan_lut = 16'd10;
         4'd13:   atan_lut = 16'd5;
         4'd14:   atan_lut = 16'd3;
         default: atan_lut = 16'd1;
      endcase
   endfunction

   // Register read mux; unmapped offsets read as zero
   always_comb begin
      rd_mux = '0;
      case (wbs_adr_i[7:0])
         8'h00:   rd_mux = {31'd0, ctrl_en};
         8'h04:   rd_mux = {16'd0, inc_r};
         8'h08:   rd_mux = {16'd0, gain_r};
         8'h0C:   rd_mux = {{14{offset_r[17]}}, offset_r};
         default: rd_mux = '0;
      endcase
   end

   // Wishbone handshake: one-cycle ack after each request, byte-masked writes
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         ctrl_en   <= 1'b0;
         inc_r     <= 16'h1000;
         gain_r    <= 16'h4000;
         offset_r  <= '0;
      end else begin
         wbs_ack_o <= req;
         if (req && !wbs_we_i) wbs_dat_o <= rd_mux;
         if (req && wbs_we_i) begin
            case (wbs_adr_i[7:0])
               8'h00: if (wbs_sel_i[0]) ctrl_en <= wbs_dat_i[0];
               8'h04: begin
                  if (wbs_sel_i[0]) inc_r[7:0]  <= wbs_dat_i[7:0];
                  if (wbs_sel_i[1]) inc_r[15:8] <= wbs_dat_i[15:8];
               end
               8'h08: begin
                  if (wbs_sel_i[0]) gain_r[7:0]  <= wbs_dat_i[7:0];
                  if (wbs_sel_i[1]) gain_r[15:8] <= wbs_dat_i[15:8];
               end
               8'h0C: begin
                  if (wbs_sel_i[0]) offset_r[7:0]   <= wbs_dat_i[7:0];
                  if (wbs_sel_i[1]) offset_r[15:8]  <= wbs_dat_i[15:8];
                  if (wbs_sel_i[2]) offset_r[17:16] <= wbs_dat_i[17:16];
               end
               default: ;
            endcase
         end
      end
   end

   // One CORDIC micro-rotation, steering the residual angle toward zero
   always_comb begin
      shift = cnt[3:0];
      x_sh  = cx >>> shift;
      y_sh  = cy >>> shift;
      step  = {3'b000, atan_lut(shift)};
      if (!cz[18]) begin
         x_nxt = cx - y_sh;
         y_nxt = cy + x_sh;
         z_nxt = cz - step;
      end else begin
         x_nxt = cx + y_sh;
         y_nxt = cy - x_sh;
         z_nxt = cz + step;
      end
   end

   // Quadrant unfold, rounding to 1.0 = 65536, gain/offset and saturation
   always_comb begin
      case (quad)
         2'd0:    unf = cy;
         2'd1:    unf = cx;
         2'd2:    unf = -cy;
         default: unf = -cx;
      endcase
      rnd      = (unf + 24'sd8) >>> 4;
      sin_s    = rnd[17:0];
      sin_ext  = {{17{sin_s[17]}}, sin_s};
      gain_ext = {19'd0, gain_r};
      scaled   = prod >>> 14;
      sum      = scaled + {{17{offset_r[17]}}, offset_r};
      if (sum > 35'sd131071)       sat = 18'h1FFFF;
      else if (sum < -35'sd131072) sat = 18'h20000;
      else                         sat = sum[17:0];
   end

   // Sequencer: load angle, iterate, scale, saturate, then hold until accepted
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state                 <= IDLE;
         cnt                   <= '0;
         phase                 <= '0;
         quad                  <= '0;
         cx                    <= '0;
         cy                    <= '0;
         cz                    <= '0;
         prod                  <= '0;
         wfg_stim_spi_tvalid_i <= 1'b0;
         wfg_stim_spi_tdata_i  <= '0;
      end else if (!ctrl_en) begin
         state                 <= IDLE;
         cnt                   <= '0;
         phase                 <= '0;
         wfg_stim_spi_tvalid_i <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= CALC;
               cnt   <= '0;
               quad  <= phase[15:14];
               cx    <= X_INIT;
               cy    <= '0;
               cz    <= {3'b000, phase[13:0], 2'b00};
            end
            CALC: begin
               cnt <= cnt + 5'd1;
               if (cnt < 5'd16) begin
                  cx <= x_nxt;
                  cy <= y_nxt;
                  cz <= z_nxt;
               end else if (cnt == 5'd16) begin
                  prod <= sin_ext * gain_ext;
               end else begin
                  wfg_stim_spi_tdata_i  <= sat;
                  wfg_stim_spi_tvalid_i <= 1'b1;
                  state                 <= VALID;
               end
            end
            VALID: begin
               if (wfg_stim_spi_tready_o) begin
                  wfg_stim_spi_tvalid_i <= 1'b0;
                  phase                 <= phase_nxt;
                  state                 <= CALC;
                  cnt                   <= '0;
                  quad                  <= phase_nxt[15:14];
                  cx                    <= X_INIT;
                  cy                    <= '0;
                  cz                    <= {3'b000, phase_nxt[13:0], 2'b00};
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wfg_stim_sine_top.sv
// Directed bench for the sine stimulus generator: register map, sample sequence,
// gain/offset/saturation, backpressure, enable clearing and mid-run reset.
module tb_wfg_stim_sine_top;

   logic               clk = 1'b0;
   logic               rst;
   logic               stb, cyc, we;
   logic [3:0]         sel;
   logic [31:0]        wdat, adr, rdat;
   logic               ack;
   logic               tready, tvalid;
   logic signed [17:0] tdata;

   int checks = 0;
   int errors = 0;

   wfg_stim_sine_top #(.BUSW(32)) dut (
      .wb_clk_i              (clk),
      .wb_rst_i              (rst),
      .wbs_stb_i             (stb),
      .wbs_cyc_i             (cyc),
      .wbs_we_i              (we),
      .wbs_sel_i             (sel),
      .wbs_dat_i             (wdat),
      .wbs_adr_i             (adr),
      .wbs_ack_o             (ack),
      .wbs_dat_o             (rdat),
      .wfg_stim_spi_tready_o (tready),
      .wfg_stim_spi_tvalid_i (tvalid),
      .wfg_stim_spi_tdata_i  (tdata)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_tol(input string tag, input int obs, input int exp_v, input int tol);
      checks++;
      assert (obs >= exp_v - tol && obs <= exp_v + tol) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d (+/-%0d)", tag, obs, exp_v, tol);
      end
   endtask

   task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r);
      int   lat;
      logic ack_after;
      @(posedge clk); #1;
      stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (ack !== 1'b1 && lat < 8);
      r   = rdat;
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      ack_after = ack;
      chk_tol("ack_latency", lat, 1, 0);
      chk_eq("ack_one_cycle", {31'd0, ack_after}, 32'd0);
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] dummy;
      wb_xfer(1'b1, a, d, s, dummy);
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
      wb_xfer(1'b0, a, 32'd0, 4'hF, r);
   endtask

   task automatic wait_valid(input string tag, input int exp_v, input int tol, output int s);
      int n;
      n = 0;
      while (tvalid !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk_eq({tag, "_tvalid"}, {31'd0, tvalid}, 32'd1);
      s = tdata;
      chk_tol(tag, s, exp_v, tol);
   endtask

   task automatic handshake();
      tready = 1'b1;
      @(posedge clk); #1;
      tready = 1'b0;
      chk_eq("tvalid_drop_after_accept", {31'd0, tvalid}, 32'd0);
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (tvalid !== 1'b0) seen = 1'b1;
      end
      chk_eq(tag, {31'd0, seen}, 32'd0);
   endtask

   initial begin
      logic [31:0] r;
      logic [3:0]  pat;
      logic        stable;
      int          s, held, n;
      int          seq1 [4];
      int          seq2 [4];
      seq1 = '{65536, 0, -65536, 0};
      seq2 = '{33768, 1000, -31768, 1000};

      rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
      wdat = '0; adr = '0; tready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rst_tvalid", {31'd0, tvalid}, 32'd0);
      chk_eq("rst_tdata", {14'd0, tdata}, 32'd0);
      chk_eq("rst_ack", {31'd0, ack}, 32'd0);
      rst = 1'b0;

      // Register reset values
      wb_read(32'h00, r); chk_eq("rd_ctrl", r, 32'h0);
      wb_read(32'h04, r); chk_eq("rd_inc", r, 32'h1000);
      wb_read(32'h08, r); chk_eq("rd_gain", r, 32'h4000);
      wb_read(32'h0C, r); chk_eq("rd_offset", r, 32'h0);
      wb_read(32'h10, r); chk_eq("rd_unmapped", r, 32'h0);

      // Byte-lane write
      wb_write(32'h04, 32'h0000ABCD, 4'b0001);
      wb_read(32'h04, r); chk_eq("inc_sel_low_byte", r, 32'h10CD);

      // Back-to-back requests: ack every other cycle
      @(posedge clk); #1;
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h08; sel = 4'hF;
      pat = '0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         pat = {pat[2:0], ack};
         if (i == 0) chk_eq("b2b_rdata", rdat, 32'h4000);
      end
      stb = 1'b0; cyc = 1'b0;
      chk_eq("b2b_ack_pattern", {28'd0, pat}, 32'hA);

      // Quarter-turn sequence at unity gain
      wb_write(32'h04, 32'h4000, 4'hF);
      wb_write(32'h00, 32'h1, 4'hF);
      n = 1;
      while (tvalid !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      assert (n >= 19 && n <= 20) else begin
         errors++;
         $error("FAIL first_valid_latency observed=%0d expected=19..20", n);
      end
      s = tdata;
      chk_tol("seq1_s0", s, 0, 4);
      handshake();
      for (int k = 0; k < 4; k++) begin
         wait_valid($sformatf("seq1_s%0d", k + 1), seq1[k], 4, s);
         handshake();
      end

      // Backpressure: hold 50 cycles, nothing lost or duplicated
      wait_valid("bp_held", 65536, 4, held);
      stable = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (tvalid !== 1'b1 || int'(tdata) != held) stable = 1'b0;
      end
      chk_eq("bp_stable", {31'd0, stable}, 32'd1);
      handshake();
      wait_valid("bp_next", 0, 4, s);
      handshake();
      wait_valid("bp_next2", -65536, 4, s);
      handshake();

      // Clear EN while a sample is held
      wait_valid("pre_clr_valid", 0, 4, s);
      wb_write(32'h00, 32'h0, 4'hF);
      chk_eq("en_clr_valid_tvalid", {31'd0, tvalid}, 32'd0);
      expect_quiet("en_clr_valid_quiet", 30);

      // Half gain plus offset
      wb_write(32'h08, 32'h2000, 4'hF);
      wb_write(32'h0C, 32'd1000, 4'hF);
      wb_write(32'h00, 32'h1, 4'hF);
      wait_valid("seq2_s0", 1000, 4, s);
      handshake();
      for (int k = 0; k < 4; k++) begin
         wait_valid($sformatf("seq2_s%0d", k + 1), seq2[k], 4, s);
         handshake();
      end

      // Clear EN mid-calculation, phase must restart at zero
      repeat (5) @(posedge clk);
      wb_write(32'h00, 32'h0, 4'hF);
      chk_eq("en_clr_calc_tvalid", {31'd0, tvalid}, 32'd0);
      expect_quiet("en_clr_calc_quiet", 30);
      wb_write(32'h00, 32'h1, 4'hF);
      wait_valid("reenable_first", 1000, 4, s);
      handshake();

      // Saturation at both rails
      wb_write(32'h00, 32'h0, 4'hF);
      wb_write(32'h08, 32'hFFFF, 4'hF);
      wb_write(32'h0C, 32'h0001FFFF, 4'hF);
      wb_read(32'h0C, r); chk_eq("rd_offset_pos", r, 32'h0001FFFF);
      wb_write(32'h00, 32'h1, 4'hF);
      wait_valid("sat_s0", 131071, 8, s);
      handshake();
      wait_valid("sat_pos", 131071, 0, s);
      wb_write(32'h0C, 32'hFFFE0000, 4'hF);
      chk_tol("held_after_offset_write", int'(tdata), 131071, 0);
      wb_read(32'h0C, r); chk_eq("rd_offset_neg", r, 32'hFFFE0000);
      handshake();
      wait_valid("sat_s2", -131072, 8, s);
      handshake();
      wait_valid("sat_neg", -131072, 0, s);
      handshake();

      // Reset in the middle of a calculation
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_eq("midrst_tvalid", {31'd0, tvalid}, 32'd0);
      chk_eq("midrst_tdata", {14'd0, tdata}, 32'd0);
      wb_read(32'h00, r); chk_eq("midrst_ctrl", r, 32'h0);
      wb_read(32'h08, r); chk_eq("midrst_gain", r, 32'h4000);
      wb_read(32'h0C, r); chk_eq("midrst_offset", r, 32'h0);
      expect_quiet("midrst_quiet", 30);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wfg_stim_sine_top.md
Name: wfg_stim_sine_top

Overview:
Wishbone-programmable sine stimulus generator for the waveform generator.
- A phase accumulator drives an iterative CORDIC engine.
- The result is scaled by a gain register, shifted by an offset register and saturated.
- Samples leave as 18-bit signed words over an AXI-Stream master, normally feeding the SPI driver.
- Register access uses a 32-bit Wishbone classic slave.

Parameters:
BUSW, 32, Wishbone address/data width (only 32 supported).

Ports:
wb_clk_i  in  1  single clock for bus and datapath.
wb_rst_i  in  1  synchronous active-high reset.
wbs_stb_i  in  1  Wishbone strobe.
wbs_cyc_i  in  1  Wishbone cycle.
wbs_we_i  in  1  write enable.
wbs_sel_i  in  4  byte enables.
wbs_dat_i  in  32  write data.
wbs_adr_i  in  32  byte address.
wbs_ack_o  out  1  acknowledge.
wbs_dat_o  out  32  read data.
wfg_stim_spi_tready_o  in  1  AXI-S ready from consumer (name kept per codebase convention).
wfg_stim_spi_tvalid_i  out  1  AXI-S valid.
wfg_stim_spi_tdata_i  out  18 signed  AXI-S sample.

Behaviour:
Register map (decoded on wbs_adr_i[7:0]):
- 0x00 CTRL: bit0 EN; other bits read 0. Reset 0.
- 0x04 INC: [15:0] phase increment; full turn = 2^16. Reset 0x1000.
- 0x08 GAIN: [15:0] unsigned Q2.14, 0x4000 = 1.0. Reset 0x4000.
- 0x0C OFFSET: [17:0] signed, added to output. Reset 0. Upper bits read as sign extension.
- Other offsets: reads return 0; writes are ignored.
- Writes honour wbs_sel_i per byte.

Wishbone:
- A request is stb&cyc with ack low.
- wbs_ack_o pulses high for exactly one cycle, on the cycle after the request.
- Write data takes effect on the ack cycle; read data is valid while ack is high.
- Back-to-back requests give ack every other cycle.

Datapath:
- Phase accumulator: 16-bit, reset 0, wraps mod 2^16.
- CORDIC, rotation mode:
  - Quadrant from phase[15:14] is folded into the first quadrant before iterating.
  - 16 iterations, one per cycle.
  - arctan constants are 16-bit.
  - Initial x is pre-divided by the CORDIC gain, so the output needs no post-multiply.
  - sin result is signed 18-bit, 1.0 = 65536, within ±4 LSB of ideal.
- Output: out = ((sin * GAIN) >>> 14) + OFFSET.
  - The product is at least 34 bits wide.
  - The result saturates to [-131072, 131071].

Sequencer (states IDLE, CALC, VALID):
- Reset: state IDLE, tvalid 0, tdata 0, phase 0.
- IDLE: when EN=1, go to CALC using the current phase.
- CALC: 18 cycles after entry (16 iterations plus scale and add/saturate), register tdata, raise tvalid, go to VALID.
- VALID:
  - tdata is held stable while tvalid=1 and tready=0.
  - On tvalid&tready: drop tvalid next cycle, phase += INC, go to CALC.
- EN cleared in any state: next cycle tvalid=0, phase=0, state IDLE. Any partial result is discarded.
- INC/GAIN/OFFSET writes while running affect the next sample computed, never the held one.
- Reset mid-operation returns all registers, state and outputs to their reset values on the next edge.

Test Plan:
- Reset, then read 0x00/0x04/0x08/0x0C/0x10 -> 0, 0x1000, 0x4000, 0, 0. Each ack is a one-cycle pulse. Write then read back INC with sel=4'b0001 -> only the low byte changes.
- INC=0x4000, GAIN=0x4000, OFFSET=0, EN=1, tready=1 -> samples 0, 65536, 0, -65536 repeating (±4 LSB). First tvalid 19-20 cycles after the EN write acks.
- GAIN=0x2000, OFFSET=1000, INC=0x4000 -> 1000, 33768, 1000, -31768 (±4).
- GAIN=0xFFFF, OFFSET=0x1FFFF (131071), phase at quarter turn -> 131071 (saturated). OFFSET=-131072 at three-quarter turn -> -131072.
- Hold tready=0 for 50 cycles with tvalid high -> tdata stable and the phase does not advance. Release tready -> the sequence resumes with no sample lost or duplicated.
- Clear EN while in CALC, and separately while in VALID -> tvalid low next cycle. Re-enable -> the first sample is sin(0)*gain+offset.
